// File: rtl/spi_pkg.sv
// Shared definitions for the SPI-NOR read sequencer: FSM state encoding,
// flash opcodes and the address byte selector.
package spi_pkg;

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_CMD   = 3'd1,
        ST_ADDR  = 3'd2,
        ST_DATA  = 3'd3,
        ST_HOLD  = 3'd4,
        ST_DRAIN = 3'd5,
        ST_GAP   = 3'd6
    } spi_seq_state_t;

    localparam logic [7:0] SPI_CMD_READ      = 8'h03;
    localparam logic [7:0] SPI_CMD_FAST_READ = 8'h0B;

    // Byte idx of an nbytes-wide address, idx 0 being the most significant byte.
    function automatic logic [7:0] addr_byte(input logic [31:0] addr,
                                             input int unsigned nbytes,
                                             input int unsigned idx);
        logic [31:0] sh;
        sh = addr >> (32'd8 * (nbytes - 32'd1 - idx));
        return sh[7:0];
    endfunction

endpackage

// File: rtl/spi_flash_read_seq_if.sv
// Request, data-out and byte-engine signals of the SPI-NOR read sequencer.
// master = the sequencer, slave = its surroundings (requester, consumer, engine, flash).
interface spi_flash_read_seq_if #(
    parameter int ADDR_W = 24,
    parameter int LEN_W  = 16
);
    logic              req_valid;
    logic              req_ready;
    logic [ADDR_W-1:0] req_addr;
    logic [LEN_W-1:0]  req_len;
    logic              abort;
    logic              busy;
    logic              out_valid;
    logic [7:0]        out_data;
    logic              out_ready;
    logic              byte_start;
    logic [7:0]        byte_tx;
    logic              byte_done;
    logic [7:0]        byte_rx;
    logic              cs_n;

    modport master (
        input  req_valid, req_addr, req_len, abort, out_ready, byte_done, byte_rx,
        output req_ready, busy, out_valid, out_data, byte_start, byte_tx, cs_n
    );

    modport slave (
        output req_valid, req_addr, req_len, abort, out_ready, byte_done, byte_rx,
        input  req_ready, busy, out_valid, out_data, byte_start, byte_tx, cs_n
    );
endinterface

// File: rtl/spi_flash_read_seq.sv
// SPI-NOR READ sequencer: drives a byte engine through opcode, address and dummy
// bytes, streams the received bytes out, and owns chip select.
module spi_flash_read_seq
    import spi_pkg::*;
#(
    parameter int         ADDR_W   = 24,
    parameter int         LEN_W    = 16,
    parameter logic [7:0] CMD_READ = SPI_CMD_READ,
    parameter int         CS_GAP   = 4
) (
    input logic               clk,
    input logic               rst_n,
    spi_flash_read_seq_if.master bus
);

    localparam int unsigned    NB       = ADDR_W / 8;
    localparam int             IW       = (NB > 1) ? $clog2(NB) : 1;
    localparam int             GW       = $clog2(CS_GAP + 1);
    localparam logic [GW-1:0]  GAP_LOAD = GW'(CS_GAP - 1);
    localparam logic [IW-1:0]  IDX_LAST = IW'(NB - 1);

    spi_seq_state_t    state_r;
    logic [ADDR_W-1:0] addr_r;
    logic [LEN_W-1:0]  remaining_r;
    logic [IW-1:0]     idx_r;
    logic [GW-1:0]     gap_cnt_r;
    logic              in_flight_r;
    logic              req_ready_r;
    logic              busy_r;
    logic              out_valid_r;
    logic [7:0]        out_data_r;
    logic              byte_start_r;
    logic [7:0]        byte_tx_r;
    logic              cs_n_r;

    logic              active_s;
    logic              abort_now_s;
    logic              drain_s;
    logic              done_s;

    assign bus.req_ready  = req_ready_r;
    assign bus.busy       = busy_r;
    assign bus.out_valid  = out_valid_r;
    assign bus.out_data   = out_data_r;
    assign bus.byte_start = byte_start_r;
    assign bus.byte_tx    = byte_tx_r;
    assign bus.cs_n       = cs_n_r;

    // Abort qualification and byte completion; a done with nothing in flight is ignored.
    always_comb begin
        active_s = 1'b0;
        case (state_r)
            ST_CMD, ST_ADDR, ST_DATA, ST_HOLD: active_s = 1'b1;
            default:                          active_s = 1'b0;
        endcase
        abort_now_s = active_s & bus.abort;
        drain_s     = abort_now_s & in_flight_r & ~bus.byte_done;
        done_s      = bus.byte_done & in_flight_r;
    end

    // Sequencer FSM with all outputs registered.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_r      <= ST_IDLE;
            addr_r       <= '0;
            remaining_r  <= '0;
            idx_r        <= '0;
            gap_cnt_r    <= '0;
            in_flight_r  <= 1'b0;
            req_ready_r  <= 1'b1;
            busy_r       <= 1'b0;
            out_valid_r  <= 1'b0;
            out_data_r   <= 8'h00;
            byte_start_r <= 1'b0;
            byte_tx_r    <= 8'h00;
            cs_n_r       <= 1'b1;
        end else begin
            byte_start_r <= 1'b0;
            if (abort_now_s) begin
                // A byte still on the wire must finish before cs_n may rise.
                if (drain_s) begin
                    state_r <= ST_DRAIN;
                end else begin
                    in_flight_r <= 1'b0;
                    out_valid_r <= 1'b0;
                    cs_n_r      <= 1'b1;
                    gap_cnt_r   <= GAP_LOAD;
                    state_r     <= ST_GAP;
                end
            end else begin
                case (state_r)
                    ST_IDLE: begin
                        if (bus.req_valid && bus.req_len != '0) begin
                            addr_r       <= bus.req_addr;
                            remaining_r  <= bus.req_len;
                            cs_n_r       <= 1'b0;
                            byte_start_r <= 1'b1;
                            byte_tx_r    <= CMD_READ;
                            in_flight_r  <= 1'b1;
                            req_ready_r  <= 1'b0;
                            busy_r       <= 1'b1;
                            state_r      <= ST_CMD;
                        end
                    end
                    ST_CMD: begin
                        if (done_s) begin
                            idx_r        <= '0;
                            byte_tx_r    <= addr_byte(32'(addr_r), NB, 32'd0);
                            byte_start_r <= 1'b1;
                            state_r      <= ST_ADDR;
                        end
                    end
                    ST_ADDR: begin
                        if (done_s) begin
                            byte_start_r <= 1'b1;
                            if (idx_r == IDX_LAST) begin
                                byte_tx_r <= 8'h00;
                                state_r   <= ST_DATA;
                            end else begin
                                idx_r     <= idx_r + IW'(1);
                                byte_tx_r <= addr_byte(32'(addr_r), NB, 32'(idx_r) + 32'd1);
                            end
                        end
                    end
                    ST_DATA: begin
                        if (done_s) begin
                            in_flight_r <= 1'b0;
                            out_data_r  <= bus.byte_rx;
                            out_valid_r <= 1'b1;
                            remaining_r <= remaining_r - LEN_W'(1);
                            state_r     <= ST_HOLD;
                        end
                    end
                    ST_HOLD: begin
                        if (bus.out_ready) begin
                            out_valid_r <= 1'b0;
                            if (remaining_r != '0) begin
                                byte_start_r <= 1'b1;
                                byte_tx_r    <= 8'h00;
                                in_flight_r  <= 1'b1;
                                state_r      <= ST_DATA;
                            end else begin
                                cs_n_r    <= 1'b1;
                                gap_cnt_r <= GAP_LOAD;
                                state_r   <= ST_GAP;
                            end
                        end
                    end
                    ST_DRAIN: begin
                        if (bus.byte_done) begin
                            in_flight_r <= 1'b0;
                            out_valid_r <= 1'b0;
                            cs_n_r      <= 1'b1;
                            gap_cnt_r   <= GAP_LOAD;
                            state_r     <= ST_GAP;
                        end
                    end
                    ST_GAP: begin
                        // The IDLE cycle that follows is the last cs_n-high cycle of the gap.
                        if (gap_cnt_r <= GW'(1)) begin
                            req_ready_r <= 1'b1;
                            busy_r      <= 1'b0;
                            state_r     <= ST_IDLE;
                        end else begin
                            gap_cnt_r <= gap_cnt_r - GW'(1);
                        end
                    end
                    default: begin
                        in_flight_r <= 1'b0;
                        out_valid_r <= 1'b0;
                        cs_n_r      <= 1'b1;
                        req_ready_r <= 1'b1;
                        busy_r      <= 1'b0;
                        state_r     <= ST_IDLE;
                    end
                endcase
            end
        end
    end

endmodule

// File: tb/tb_spi_flash_read_seq.sv
// Bench for spi_flash_read_seq: behavioural byte engine plus SPI-NOR flash model,
// with expected TX/RX byte queues filled when each request is issued.
module tb_spi_flash_read_seq;

    localparam int CS_GAP = 4;

    logic clk = 1'b0;
    logic rst_n;
    logic spur_done;
    logic eng_done = 1'b0;

    always #5 clk = ~clk;

    spi_flash_read_seq_if #(.ADDR_W(24), .LEN_W(16)) bus ();

    spi_flash_read_seq #(.ADDR_W(24), .LEN_W(16), .CMD_READ(8'h03), .CS_GAP(CS_GAP)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    assign bus.byte_done = eng_done | spur_done;

    int errors = 0;
    int checks = 0;
    int lat = 2;

    logic [7:0] exp_tx[$];
    logic [7:0] exp_rx[$];
    logic [7:0] tx_obs[$];
    logic [7:0] rx_obs[$];

    int start_cnt = 0, done_cnt = 0, ov_cnt = 0, rise_cnt = 0;
    int start_ov_viol = 0, stab_viol = 0;
    int cs_hi_run = 0, last_gap = 0;
    logic prev_cs = 1'b1, prev_stall = 1'b0;
    logic [7:0] prev_data = 8'h00;

    function automatic logic [7:0] fmem(input logic [23:0] a);
        return a[7:0] ^ {a[11:8], a[15:12]} ^ a[23:16] ^ 8'h3C;
    endfunction

    // Flash model: byte 0 opcode, bytes 1..3 address, then sequential data.
    int eng_cnt = 0;
    int fl_cnt = 0;
    logic [23:0] fl_addr = 24'h0;
    always @(posedge clk) begin
        eng_done <= 1'b0;
        if (eng_cnt != 0) begin
            eng_cnt <= eng_cnt - 1;
            if (eng_cnt == 1) eng_done <= 1'b1;
        end else if (bus.byte_start) begin
            eng_cnt <= lat;
            if (fl_cnt >= 4) bus.byte_rx <= fmem(fl_addr + 24'(fl_cnt - 4));
            else             bus.byte_rx <= 8'hFF;
            if (fl_cnt >= 1 && fl_cnt <= 3) fl_addr <= {fl_addr[15:0], bus.byte_tx};
            fl_cnt <= fl_cnt + 1;
        end
        if (bus.cs_n === 1'b1) fl_cnt <= 0;
    end

    // Output monitor: captures bytes and protocol counters.
    always @(posedge clk) begin
        if (bus.byte_start === 1'b1) begin
            tx_obs.push_back(bus.byte_tx);
            start_cnt <= start_cnt + 1;
            if (bus.out_valid === 1'b1) start_ov_viol <= start_ov_viol + 1;
        end
        if (bus.out_valid === 1'b1 && bus.out_ready === 1'b1) rx_obs.push_back(bus.out_data);
        if (bus.out_valid === 1'b1) ov_cnt <= ov_cnt + 1;
        if (bus.byte_done === 1'b1) done_cnt <= done_cnt + 1;
        if (prev_stall && bus.out_valid === 1'b1 && bus.out_data !== prev_data) stab_viol <= stab_viol + 1;
        prev_stall <= (bus.out_valid === 1'b1) && (bus.out_ready !== 1'b1);
        prev_data  <= bus.out_data;
        if (bus.cs_n === 1'b1) cs_hi_run <= cs_hi_run + 1;
        else begin
            if (cs_hi_run != 0) last_gap <= cs_hi_run;
            cs_hi_run <= 0;
        end
        if (bus.cs_n === 1'b1 && prev_cs !== 1'b1) rise_cnt <= rise_cnt + 1;
        prev_cs <= bus.cs_n;
    end

    task automatic push_exp(input logic [23:0] a, input int len);
        exp_tx.push_back(8'h03);
        exp_tx.push_back(a[23:16]);
        exp_tx.push_back(a[15:8]);
        exp_tx.push_back(a[7:0]);
        for (int i = 0; i < len; i++) begin
            exp_tx.push_back(8'h00);
            exp_rx.push_back(fmem(a + 24'(i)));
        end
    endtask

    task automatic clear_q();
        exp_tx.delete(); exp_rx.delete(); tx_obs.delete(); rx_obs.delete();
    endtask

    task automatic drive_req(input logic [23:0] a, input logic [15:0] l, output bit to);
        to = 1'b1;
        for (int c = 0; c < 200; c++) begin
            @(negedge clk);
            if (bus.req_ready === 1'b1) begin to = 1'b0; break; end
        end
        bus.req_addr = a; bus.req_len = l; bus.req_valid = 1'b1;
        @(negedge clk);
        bus.req_valid = 1'b0;
    endtask

    task automatic run_consumer(input int stall, input int budget, output bit to);
        int st;
        st = 0; to = 1'b1;
        for (int c = 0; c < budget; c++) begin
            if (bus.busy === 1'b0 && bus.out_valid === 1'b0) begin to = 1'b0; break; end
            if (bus.out_valid === 1'b1 && st < stall) begin bus.out_ready = 1'b0; st++; end
            else begin bus.out_ready = 1'b1; if (bus.out_valid === 1'b1) st = 0; end
            @(negedge clk);
        end
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        repeat (3) @(negedge clk);
        checks++; if (bus.req_ready !== 1'b1) begin errors++; $display("FAIL rst_req_ready: got %b want 1", bus.req_ready); end
        checks++; if (bus.busy !== 1'b0) begin errors++; $display("FAIL rst_busy: got %b want 0", bus.busy); end
        checks++; if (bus.out_valid !== 1'b0) begin errors++; $display("FAIL rst_out_valid: got %b want 0", bus.out_valid); end
        checks++; if (bus.out_data !== 8'h00) begin errors++; $display("FAIL rst_out_data: got %h want 00", bus.out_data); end
        checks++; if (bus.byte_start !== 1'b0) begin errors++; $display("FAIL rst_byte_start: got %b want 0", bus.byte_start); end
        checks++; if (bus.byte_tx !== 8'h00) begin errors++; $display("FAIL rst_byte_tx: got %h want 00", bus.byte_tx); end
        checks++; if (bus.cs_n !== 1'b1) begin errors++; $display("FAIL rst_cs_n: got %b want 1", bus.cs_n); end
        rst_n = 1'b1;
        @(negedge clk);
    endtask

    task automatic test_single_read();
        bit to; int r0; logic [7:0] got, want;
        lat = 2; clear_q(); r0 = rise_cnt;
        push_exp(24'h012345, 3);
        drive_req(24'h012345, 16'd3, to);
        checks++; if (to) begin errors++; $display("FAIL t1_req_wait: got timeout want ready"); end
        run_consumer(0, 300, to);
        checks++; if (to) begin errors++; $display("FAIL t1_done_wait: got timeout want idle"); end
        repeat (2) @(negedge clk);
        checks++; if (rise_cnt - r0 != 1) begin errors++; $display("FAIL t1_cs_rises: got %0d want 1", rise_cnt - r0); end
        checks++; if (cs_hi_run < CS_GAP) begin errors++; $display("FAIL t1_cs_gap: got %0d want >=%0d", cs_hi_run, CS_GAP); end
        checks++; if (tx_obs.size() != exp_tx.size()) begin errors++; $display("FAIL t1_tx_count: got %0d want %0d", tx_obs.size(), exp_tx.size()); end
        while (tx_obs.size() > 0 && exp_tx.size() > 0) begin
            got = tx_obs.pop_front(); want = exp_tx.pop_front();
            checks++; if (got !== want) begin errors++; $display("FAIL t1_tx_byte: got %h want %h", got, want); end
        end
        checks++; if (rx_obs.size() != exp_rx.size()) begin errors++; $display("FAIL t1_rx_count: got %0d want %0d", rx_obs.size(), exp_rx.size()); end
        while (rx_obs.size() > 0 && exp_rx.size() > 0) begin
            got = rx_obs.pop_front(); want = exp_rx.pop_front();
            checks++; if (got !== want) begin errors++; $display("FAIL t1_rx_byte: got %h want %h", got, want); end
        end
    endtask

    task automatic test_zero_len();
        int s0;
        for (int c = 0; c < 50 && bus.req_ready !== 1'b1; c++) @(negedge clk);
        s0 = start_cnt;
        bus.req_addr = 24'h00ABCD; bus.req_len = 16'd0; bus.req_valid = 1'b1;
        @(negedge clk);
        bus.req_valid = 1'b0;
        checks++; if (bus.req_ready !== 1'b1) begin errors++; $display("FAIL t2_req_ready: got %b want 1", bus.req_ready); end
        checks++; if (bus.cs_n !== 1'b1) begin errors++; $display("FAIL t2_cs_n: got %b want 1", bus.cs_n); end
        repeat (5) @(negedge clk);
        checks++; if (start_cnt != s0) begin errors++; $display("FAIL t2_starts: got %0d want %0d", start_cnt, s0); end
        checks++; if (bus.busy !== 1'b0) begin errors++; $display("FAIL t2_busy: got %b want 0", bus.busy); end
    endtask

    task automatic test_stall();
        bit to; int v0, d0; logic [7:0] got, want;
        lat = 3; clear_q(); v0 = start_ov_viol; d0 = stab_viol;
        push_exp(24'h7F00FE, 4);
        drive_req(24'h7F00FE, 16'd4, to);
        checks++; if (to) begin errors++; $display("FAIL t3_req_wait: got timeout want ready"); end
        run_consumer(10, 400, to);
        checks++; if (to) begin errors++; $display("FAIL t3_done_wait: got timeout want idle"); end
        checks++; if (start_ov_viol != v0) begin errors++; $display("FAIL t3_start_while_valid: got %0d want %0d", start_ov_viol, v0); end
        checks++; if (stab_viol != d0) begin errors++; $display("FAIL t3_data_stable: got %0d want %0d", stab_viol, d0); end
        checks++; if (rx_obs.size() != exp_rx.size()) begin errors++; $display("FAIL t3_rx_count: got %0d want %0d", rx_obs.size(), exp_rx.size()); end
        while (rx_obs.size() > 0 && exp_rx.size() > 0) begin
            got = rx_obs.pop_front(); want = exp_rx.pop_front();
            checks++; if (got !== want) begin errors++; $display("FAIL t3_rx_byte: got %h want %h", got, want); end
        end
    endtask

    task automatic test_abort();
        bit to, seen, prev_done; int d0, o0, n;
        logic [7:0] got, want;
        lat = 3; clear_q();
        exp_tx.push_back(8'h03); exp_tx.push_back(8'h12); exp_tx.push_back(8'h34);
        drive_req(24'h123456, 16'd2, to);
        checks++; if (to) begin errors++; $display("FAIL t4_req_wait: got timeout want ready"); end
        for (int c = 0; c < 50 && tx_obs.size() < 3; c++) @(negedge clk);
        bus.abort = 1'b1; d0 = done_cnt; o0 = ov_cnt;
        seen = 1'b0; prev_done = 1'b0;
        for (int c = 0; c < 50; c++) begin
            @(negedge clk);
            if (bus.cs_n === 1'b1) begin seen = 1'b1; break; end
            prev_done = bus.byte_done;
        end
        bus.abort = 1'b0;
        checks++; if (!seen) begin errors++; $display("FAIL t4_cs_rise: got timeout want cs_n=1"); end
        checks++; if (prev_done !== 1'b1) begin errors++; $display("FAIL t4_cs_after_done: got %b want 1", prev_done); end
        checks++; if (done_cnt - d0 != 1) begin errors++; $display("FAIL t4_drained: got %0d want 1", done_cnt - d0); end
        n = 0;
        for (int c = 0; c < 20 && bus.req_ready !== 1'b1; c++) begin @(negedge clk); n++; end
        checks++; if (n < CS_GAP - 1 || n > CS_GAP) begin errors++; $display("FAIL t4_gap_to_idle: got %0d want %0d..%0d", n, CS_GAP - 1, CS_GAP); end
        checks++; if (ov_cnt != o0) begin errors++; $display("FAIL t4_out_valid: got %0d want %0d", ov_cnt, o0); end
        checks++; if (tx_obs.size() != exp_tx.size()) begin errors++; $display("FAIL t4_tx_count: got %0d want %0d", tx_obs.size(), exp_tx.size()); end
        while (tx_obs.size() > 0 && exp_tx.size() > 0) begin
            got = tx_obs.pop_front(); want = exp_tx.pop_front();
            checks++; if (got !== want) begin errors++; $display("FAIL t4_tx_byte: got %h want %h", got, want); end
        end
    endtask

    task automatic test_reset_mid();
        bit to, seen; int s0; logic [7:0] got, want;
        lat = 2; clear_q(); bus.out_ready = 1'b0;
        drive_req(24'h000100, 16'd3, to);
        seen = 1'b0;
        for (int c = 0; c < 100; c++) begin
            if (bus.out_valid === 1'b1) begin seen = 1'b1; break; end
            @(negedge clk);
        end
        checks++; if (!seen) begin errors++; $display("FAIL t5_valid_wait: got timeout want out_valid"); end
        rst_n = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        checks++; if (bus.out_valid !== 1'b0) begin errors++; $display("FAIL t5_out_valid: got %b want 0", bus.out_valid); end
        checks++; if (bus.cs_n !== 1'b1) begin errors++; $display("FAIL t5_cs_n: got %b want 1", bus.cs_n); end
        checks++; if (bus.req_ready !== 1'b1) begin errors++; $display("FAIL t5_req_ready: got %b want 1", bus.req_ready); end
        s0 = start_cnt;
        spur_done = 1'b1;
        @(negedge clk);
        spur_done = 1'b0;
        repeat (3) @(negedge clk);
        checks++; if (start_cnt != s0 || bus.busy !== 1'b0) begin errors++; $display("FAIL t5_stale_done: got starts=%0d busy=%b want starts=%0d busy=0", start_cnt, bus.busy, s0); end
        clear_q();
        push_exp(24'h3C3C3C, 2);
        drive_req(24'h3C3C3C, 16'd2, to);
        run_consumer(1, 300, to);
        checks++; if (to) begin errors++; $display("FAIL t5_done_wait: got timeout want idle"); end
        checks++; if (rx_obs.size() != exp_rx.size()) begin errors++; $display("FAIL t5_rx_count: got %0d want %0d", rx_obs.size(), exp_rx.size()); end
        while (rx_obs.size() > 0 && exp_rx.size() > 0) begin
            got = rx_obs.pop_front(); want = exp_rx.pop_front();
            checks++; if (got !== want) begin errors++; $display("FAIL t5_rx_byte: got %h want %h", got, want); end
        end
    endtask

    task automatic test_back_to_back();
        bit to, seen; logic [7:0] got, want;
        lat = 1; clear_q(); bus.out_ready = 1'b1;
        push_exp(24'h0000F0, 2);
        push_exp(24'hFFFFFE, 2);
        for (int c = 0; c < 50; c++) begin
            @(negedge clk);
            if (bus.req_ready === 1'b1) break;
        end
        bus.req_addr = 24'h0000F0; bus.req_len = 16'd2; bus.req_valid = 1'b1;
        @(negedge clk);
        bus.req_addr = 24'hFFFFFE;
        seen = 1'b0;
        for (int c = 0; c < 200; c++) begin
            @(negedge clk);
            if (bus.req_ready === 1'b1) begin seen = 1'b1; break; end
        end
        @(negedge clk);
        bus.req_valid = 1'b0;
        checks++; if (!seen) begin errors++; $display("FAIL t6_second_req: got timeout want ready"); end
        run_consumer(0, 300, to);
        checks++; if (to) begin errors++; $display("FAIL t6_done_wait: got timeout want idle"); end
        checks++; if (last_gap != CS_GAP) begin errors++; $display("FAIL t6_cs_gap: got %0d want %0d", last_gap, CS_GAP); end
        checks++; if (tx_obs.size() != exp_tx.size()) begin errors++; $display("FAIL t6_tx_count: got %0d want %0d", tx_obs.size(), exp_tx.size()); end
        while (tx_obs.size() > 0 && exp_tx.size() > 0) begin
            got = tx_obs.pop_front(); want = exp_tx.pop_front();
            checks++; if (got !== want) begin errors++; $display("FAIL t6_tx_byte: got %h want %h", got, want); end
        end
        checks++; if (rx_obs.size() != exp_rx.size()) begin errors++; $display("FAIL t6_rx_count: got %0d want %0d", rx_obs.size(), exp_rx.size()); end
        while (rx_obs.size() > 0 && exp_rx.size() > 0) begin
            got = rx_obs.pop_front(); want = exp_rx.pop_front();
            checks++; if (got !== want) begin errors++; $display("FAIL t6_rx_byte: got %h want %h", got, want); end
        end
    endtask

    initial begin
        rst_n = 1'b0; spur_done = 1'b0;
        bus.req_valid = 1'b0; bus.req_addr = 24'h0; bus.req_len = 16'h0;
        bus.abort = 1'b0; bus.out_ready = 1'b0;
        test_reset();
        test_single_read();
        test_zero_len();
        test_stall();
        test_abort();
        test_reset_mid();
        test_back_to_back();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
